soc_timer: RTL and testbench
============================

# soc_timer

Memory-mapped RISC-V machine timer on the peripheral register bus. It drives the CPU subsystem's `time_irq_i` input, which is currently tied off. The block holds a 64-bit `mtime` counter advanced by a programmable prescaler and a 64-bit `mtimecmp` compare register. It raises a level timer interrupt while `mtime >= mtimecmp`.

## Interface
- `reg_req_t`, default `core_v_mcu_pkg::reg_req_t`: register-interface request type (32-bit addr/data, wstrb, write, valid).
- `reg_rsp_t`, default `core_v_mcu_pkg::reg_rsp_t`: register-interface response type (rdata, error, ready).
- `PrescaleWidth`, default 16: width of the prescaler reload field.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `reg_req_i`  in  reg_req_t  register bus request, from the bus subsystem's `SOC_TIMER_REG_IDX` slot.
- `reg_rsp_o`  out  reg_rsp_t  register bus response.
- `time_irq_o`  out  1  machine timer interrupt, to cpu_subsystem `time_irq_i`.
- `mtime_o`  out  64  current `mtime`, for debug/trace.

## Operation
- Register map (byte offsets, 32-bit words):
  - 0x00 CTRL: bit0 EN, bit1 IRQ_EN.
  - 0x04 PRESCALE: `[PrescaleWidth-1:0]` reload value.
  - 0x08 MTIME_LO.
  - 0x0C MTIME_HI.
  - 0x10 MTIMECMP_LO.
  - 0x14 MTIMECMP_HI.
  - 0x18 STATUS: bit0 PENDING, read-only (RO).
- Reset values:
  - CTRL=0, PRESCALE=0, mtime=0.
  - mtimecmp=all-ones, cmp staging=all-ones, read shadow=0.
  - prescale counter=0, `time_irq_o`=0.
- Prescaler:
  - While EN=1, the counter counts 0..PRESCALE.
  - The cycle the counter equals PRESCALE is a tick: the counter returns to 0 and mtime increments by 1.
  - PRESCALE=0 gives one increment per cycle.
  - While EN=0, the counter is held at 0 and mtime holds.
  - Any PRESCALE write clears the counter to 0.
- mtime is unsigned 64-bit and wraps from 2^64-1 to 0.
- Writes:
  - Byte strobes are honoured on all writable registers.
  - A software write to MTIME_LO/HI updates only that half. The increment is suppressed in the write cycle: the write wins and the prescaler tick is consumed.
- Atomic mtimecmp update:
  - A write to MTIMECMP_LO goes to a staging register only.
  - A write to MTIMECMP_HI commits {wdata, staging} to mtimecmp in one cycle.
  - A read of MTIMECMP_LO returns the staging value. A read of MTIMECMP_HI returns mtimecmp[63:32].
- Atomic mtime read:
  - A read of MTIME_LO returns mtime[31:0] and snapshots mtime[63:32] into the shadow.
  - A read of MTIME_HI returns the shadow.
- Compare and interrupt:
  - PENDING = (mtime >= mtimecmp), unsigned 64-bit compare, independent of IRQ_EN.
  - `time_irq_o` is registered: PENDING && IRQ_EN.
  - The interrupt is cleared only by raising mtimecmp or clearing IRQ_EN. There is no W1C.
- Errors:
  - An access with addr[1:0]≠0, or to an offset above 0x18, returns error=1 with rdata=0 and no state change.
  - Writes to STATUS are ignored, with error=0.

## Timing
- `reg_rsp_o.ready` = `reg_req_i.valid`, combinationally: zero wait states.
- rdata and error are combinational from current register state.
- Register writes take effect at the clock edge where valid && write.
- Interrupt latency: mtime reaches mtimecmp at edge N; `time_irq_o` rises after edge N+1.
- After an mtimecmp commit or IRQ_EN clear at edge N, `time_irq_o` falls after edge N+1.
- A tick and a CTRL write clearing EN in the same cycle: the increment still occurs and the counter stops afterwards.
- Asynchronous reset mid-operation: all state returns to reset values immediately and `time_irq_o` drops with no clock.

## Structure
- `core_v_mcu_pkg` holds:
  - `SOC_TIMER_REG_IDX` and the block's base address.
  - The register offset localparams.
- The top handles the register decode, shadow/staging, compare and IRQ flop.
- One sub-module is natural: `soc_timer_prescaler` (counter, reload, clear-on-write, tick output).
- Estimated 200–300 lines total.

## Test plan
- Reset; read all offsets. Expect CTRL=0, MTIME=0, MTIMECMP_HI=0xFFFFFFFF, STATUS=0, `time_irq_o`=0.
- PRESCALE=3, EN=1, run 40 cycles. Expect mtime=10 (±1 at the write boundary) and increments exactly every 4 cycles on `mtime_o`.
- mtimecmp={0,20}, PRESCALE=0, IRQ_EN=1, EN=1:
  - `time_irq_o` rises one cycle after `mtime_o`=20.
  - Write MTIMECMP_LO=100: the output stays high.
  - Write MTIMECMP_HI=0: the output falls one cycle later.
- Write MTIME_LO=0xFFFFFFFE, HI=0xFFFFFFFF, EN=1, PRESCALE=0:
  - Wrap to 0 after 2 cycles.
  - A LO read at value 0xFFFFFFFF followed by a HI read after the wrap returns shadow 0xFFFFFFFF.
- Read at 0x1C and at 0x02. Expect error=1, rdata=0, ready=1, no state change.
- Write MTIME_LO with wstrb=0b0001, wdata=0xAA, while mtime=0x12345678 and EN=0. Expect MTIME_LO=0x123456AA.

Source files
------------

// File: rtl/core_v_mcu_pkg.sv
// Shared SoC definitions: register-bus types, timer slot/base address, register offsets.
// Also holds the byte-strobe merge helper used by every writable register.
package core_v_mcu_pkg;

    localparam int unsigned SOC_TIMER_REG_IDX   = 32'd9;
    localparam logic [31:0] SOC_TIMER_BASE_ADDR = 32'h1A10_B000;

    localparam logic [4:0] SOC_TIMER_CTRL_OFFSET        = 5'h00;
    localparam logic [4:0] SOC_TIMER_PRESCALE_OFFSET    = 5'h04;
    localparam logic [4:0] SOC_TIMER_MTIME_LO_OFFSET    = 5'h08;
    localparam logic [4:0] SOC_TIMER_MTIME_HI_OFFSET    = 5'h0C;
    localparam logic [4:0] SOC_TIMER_MTIMECMP_LO_OFFSET = 5'h10;
    localparam logic [4:0] SOC_TIMER_MTIMECMP_HI_OFFSET = 5'h14;
    localparam logic [4:0] SOC_TIMER_STATUS_OFFSET      = 5'h18;
    localparam logic [31:0] SOC_TIMER_LAST_OFFSET       = 32'h0000_0018;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                res[8*b +: 8] = cur[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_timer_prescaler.sv
// Prescaler for the machine timer: counts 0..reload while enabled and flags a tick
// on the cycle the count equals reload. A reload write restarts the count from zero.
module soc_timer_prescaler #(
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en,
    input  logic                     clear,
    input  logic [PrescaleWidth-1:0] reload,
    output logic                     tick
);

    logic [PrescaleWidth-1:0] count_r;
    logic [PrescaleWidth-1:0] count_next_s;
    logic                     at_reload_s;

    // Tick generation and next count; the tick uses the current enable so a
    // same-cycle disable still lets the pending increment through.
    always_comb begin
        at_reload_s  = (count_r == reload);
        tick         = en && at_reload_s;
        count_next_s = count_r;
        if (clear) begin
            count_next_s = '0;
        end else if (!en) begin
            count_next_s = '0;
        end else if (at_reload_s) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_r + PrescaleWidth'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= '0;
        end else begin
            count_r <= count_next_s;
        end
    end

endmodule

// File: rtl/soc_timer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, atomic mtimecmp commit through a
// staging word, atomic mtime read through a high-half shadow, and a registered level IRQ.
module soc_timer
    import core_v_mcu_pkg::*;
#(
    parameter type         reg_req_t     = core_v_mcu_pkg::reg_req_t,
    parameter type         reg_rsp_t     = core_v_mcu_pkg::reg_rsp_t,
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  reg_req_t    reg_req_i,
    output reg_rsp_t    reg_rsp_o,
    output logic        time_irq_o,
    output logic [63:0] mtime_o
);

    logic [1:0]               ctrl_r;
    logic [PrescaleWidth-1:0] prescale_r;
    logic [63:0]              mtime_r;
    logic [63:0]              mtimecmp_r;
    logic [31:0]              cmp_stage_r;
    logic [31:0]              shadow_r;
    logic                     irq_r;

    logic [31:0] off_s;
    logic        addr_err_s;
    logic        wr_s;
    logic        rd_s;
    logic        wr_ctrl_s;
    logic        wr_prescale_s;
    logic        wr_mtime_lo_s;
    logic        wr_mtime_hi_s;
    logic        wr_cmp_lo_s;
    logic        wr_cmp_hi_s;
    logic        rd_mtime_lo_s;
    logic        pending_s;
    logic        tick_s;
    logic [31:0] rdata_s;

    // Address decode: the offset is taken against the block base, so anything outside
    // the seven-word window or misaligned is rejected without touching state.
    always_comb begin
        off_s         = reg_req_i.addr - SOC_TIMER_BASE_ADDR;
        addr_err_s    = (reg_req_i.addr[1:0] != 2'b00) || (off_s > SOC_TIMER_LAST_OFFSET);
        wr_s          = reg_req_i.valid && reg_req_i.write && !addr_err_s;
        rd_s          = reg_req_i.valid && !reg_req_i.write && !addr_err_s;
        wr_ctrl_s     = wr_s && (off_s[4:0] == SOC_TIMER_CTRL_OFFSET);
        wr_prescale_s = wr_s && (off_s[4:0] == SOC_TIMER_PRESCALE_OFFSET);
        wr_mtime_lo_s = wr_s && (off_s[4:0] == SOC_TIMER_MTIME_LO_OFFSET);
        wr_mtime_hi_s = wr_s && (off_s[4:0] == SOC_TIMER_MTIME_HI_OFFSET);
        wr_cmp_lo_s   = wr_s && (off_s[4:0] == SOC_TIMER_MTIMECMP_LO_OFFSET);
        wr_cmp_hi_s   = wr_s && (off_s[4:0] == SOC_TIMER_MTIMECMP_HI_OFFSET);
        rd_mtime_lo_s = rd_s && (off_s[4:0] == SOC_TIMER_MTIME_LO_OFFSET);
        pending_s     = (mtime_r >= mtimecmp_r);
    end

    // Read mux and zero-wait-state response.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (off_s[4:0])
            SOC_TIMER_CTRL_OFFSET:        rdata_s = {30'd0, ctrl_r};
            SOC_TIMER_PRESCALE_OFFSET:    rdata_s = 32'(prescale_r);
            SOC_TIMER_MTIME_LO_OFFSET:    rdata_s = mtime_r[31:0];
            SOC_TIMER_MTIME_HI_OFFSET:    rdata_s = shadow_r;
            SOC_TIMER_MTIMECMP_LO_OFFSET: rdata_s = cmp_stage_r;
            SOC_TIMER_MTIMECMP_HI_OFFSET: rdata_s = mtimecmp_r[63:32];
            SOC_TIMER_STATUS_OFFSET:      rdata_s = {31'd0, pending_s};
            default:                      rdata_s = 32'h0000_0000;
        endcase
        reg_rsp_o       = '0;
        reg_rsp_o.ready = reg_req_i.valid;
        if (reg_req_i.valid && addr_err_s) begin
            reg_rsp_o.error = 1'b1;
            reg_rsp_o.rdata = 32'h0000_0000;
        end else begin
            reg_rsp_o.error = 1'b0;
            reg_rsp_o.rdata = rdata_s;
        end
    end

    soc_timer_prescaler #(
        .PrescaleWidth (PrescaleWidth)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (ctrl_r[0]),
        .clear  (wr_prescale_s),
        .reload (prescale_r),
        .tick   (tick_s)
    );

    // Control and prescale registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_r     <= 2'b00;
            prescale_r <= '0;
        end else begin
            if (wr_ctrl_s) begin
                ctrl_r <= 2'(apply_wstrb({30'd0, ctrl_r}, reg_req_i.wdata, reg_req_i.wstrb));
            end
            if (wr_prescale_s) begin
                prescale_r <= PrescaleWidth'(apply_wstrb(32'(prescale_r), reg_req_i.wdata,
                                                         reg_req_i.wstrb));
            end
        end
    end

    // mtime: a software write to either half wins over the tick in that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_r <= 64'd0;
        end else if (wr_mtime_lo_s) begin
            mtime_r[31:0] <= apply_wstrb(mtime_r[31:0], reg_req_i.wdata, reg_req_i.wstrb);
        end else if (wr_mtime_hi_s) begin
            mtime_r[63:32] <= apply_wstrb(mtime_r[63:32], reg_req_i.wdata, reg_req_i.wstrb);
        end else if (tick_s) begin
            mtime_r <= mtime_r + 64'd1;
        end
    end

    // Compare staging/commit and the read shadow for tear-free 64-bit access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
            cmp_stage_r <= 32'hFFFF_FFFF;
            shadow_r    <= 32'h0000_0000;
        end else begin
            if (wr_cmp_lo_s) begin
                cmp_stage_r <= apply_wstrb(cmp_stage_r, reg_req_i.wdata, reg_req_i.wstrb);
            end
            if (wr_cmp_hi_s) begin
                mtimecmp_r <= {apply_wstrb(mtimecmp_r[63:32], reg_req_i.wdata, reg_req_i.wstrb),
                               cmp_stage_r};
            end
            if (rd_mtime_lo_s) begin
                shadow_r <= mtime_r[63:32];
            end
        end
    end

    // Interrupt flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= pending_s && ctrl_r[1];
        end
    end

    assign time_irq_o = irq_r;
    assign mtime_o    = mtime_r;

endmodule

// File: tb/tb_soc_timer.sv
// Directed bench for soc_timer: register map, prescaler cadence, IRQ latency,
// atomic 64-bit access, error responses, byte strobes and asynchronous reset.
module tb_soc_timer;
    import core_v_mcu_pkg::*;

    localparam logic [11:0] O_CTRL   = 12'h000;
    localparam logic [11:0] O_PRE    = 12'h004;
    localparam logic [11:0] O_MLO    = 12'h008;
    localparam logic [11:0] O_MHI    = 12'h00C;
    localparam logic [11:0] O_CLO    = 12'h010;
    localparam logic [11:0] O_CHI    = 12'h014;
    localparam logic [11:0] O_STATUS = 12'h018;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    reg_req_t    req;
    reg_rsp_t    rsp;
    logic        irq;
    logic [63:0] mtime;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] rd;
    logic        er;
    logic        rdy;

    soc_timer dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .reg_req_i  (req),
        .reg_rsp_o  (rsp),
        .time_irq_o (irq),
        .mtime_o    (mtime)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] off, input logic [31:0] data,
                             input logic [3:0] strb, output logic err);
        @(negedge clk_i);
        req.addr  = SOC_TIMER_BASE_ADDR + {20'd0, off};
        req.write = 1'b1;
        req.wdata = data;
        req.wstrb = strb;
        req.valid = 1'b1;
        #1;
        err = rsp.error;
        @(posedge clk_i);
        #1;
        req = '0;
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] data);
        logic e;
        bus_write(off, data, 4'hF, e);
    endtask

    task automatic bus_read(input logic [11:0] off, output logic [31:0] data,
                            output logic err, output logic ready);
        @(negedge clk_i);
        req.addr  = SOC_TIMER_BASE_ADDR + {20'd0, off};
        req.write = 1'b0;
        req.wdata = 32'h0;
        req.wstrb = 4'h0;
        req.valid = 1'b1;
        #1;
        data  = rsp.rdata;
        err   = rsp.error;
        ready = rsp.ready;
        @(posedge clk_i);
        #1;
        req = '0;
    endtask

    task automatic read_check(input string tag, input logic [11:0] off, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        logic        r;
        bus_read(off, d, e, r);
        check_value(tag, {32'd0, d}, {32'd0, exp});
    endtask

    initial begin
        req    = '0;
        rst_ni = 1'b0;
        #12;
        check_value("rst_irq", {63'd0, irq}, 64'd0);
        check_value("rst_mtime", mtime, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        read_check("rst_ctrl", O_CTRL, 32'h0);
        read_check("rst_pre", O_PRE, 32'h0);
        read_check("rst_mlo", O_MLO, 32'h0);
        read_check("rst_mhi", O_MHI, 32'h0);
        read_check("rst_clo", O_CLO, 32'hFFFF_FFFF);
        read_check("rst_chi", O_CHI, 32'hFFFF_FFFF);
        read_check("rst_status", O_STATUS, 32'h0);

        // Prescale 3: one increment every 4 cycles, first at the 4th edge after enable.
        wr(O_PRE, 32'd3);
        wr(O_CTRL, 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i);
            #1;
            check_value($sformatf("pre3_k%0d", k), mtime, 64'(k / 4));
        end
        wr(O_CTRL, 32'd0);
        read_check("pre3_final", O_MLO, 32'd10);

        // Compare at 20 with prescale 0.
        wr(O_PRE, 32'd0);
        wr(O_MLO, 32'd0);
        wr(O_CLO, 32'd20);
        wr(O_CHI, 32'd0);
        read_check("cmp_hi", O_CHI, 32'd0);
        read_check("cmp_stage", O_CLO, 32'd20);
        wr(O_CTRL, 32'd3);
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk_i);
            #1;
            check_value($sformatf("irq_mt_k%0d", k), mtime, 64'(k));
            check_value($sformatf("irq_k%0d", k), {63'd0, irq}, {63'd0, (k >= 21)});
        end
        wr(O_CLO, 32'd100);
        check_value("irq_stage_only", {63'd0, irq}, 64'd1);
        wr(O_CHI, 32'd0);
        check_value("irq_commit_edge", {63'd0, irq}, 64'd1);
        @(posedge clk_i);
        #1;
        check_value("irq_commit_fall", {63'd0, irq}, 64'd0);
        read_check("status_clear", O_STATUS, 32'd0);

        // Wrap and shadow read.
        wr(O_CTRL, 32'd0);
        wr(O_MLO, 32'hFFFF_FFFE);
        wr(O_MHI, 32'hFFFF_FFFF);
        wr(O_CTRL, 32'd1);
        check_value("wrap_m2", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk_i);
        #1;
        check_value("wrap_m1", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        read_check("wrap_lo", O_MLO, 32'hFFFF_FFFF);
        check_value("wrap_zero", mtime, 64'd0);
        read_check("wrap_shadow", O_MHI, 32'hFFFF_FFFF);
        wr(O_CTRL, 32'd0);
        check_value("wrap_stop", mtime, 64'd2);

        // Error responses.
        bus_read(12'h01C, rd, er, rdy);
        check_value("err1c_err", {63'd0, er}, 64'd1);
        check_value("err1c_rdata", {32'd0, rd}, 64'd0);
        check_value("err1c_ready", {63'd0, rdy}, 64'd1);
        bus_read(12'h002, rd, er, rdy);
        check_value("err02_err", {63'd0, er}, 64'd1);
        check_value("err02_rdata", {32'd0, rd}, 64'd0);
        check_value("err02_ready", {63'd0, rdy}, 64'd1);
        bus_write(12'h002, 32'd3, 4'hF, er);
        check_value("errw02_err", {63'd0, er}, 64'd1);
        bus_write(12'h00A, 32'h5555_5555, 4'hF, er);
        check_value("errw0a_err", {63'd0, er}, 64'd1);
        read_check("errw_ctrl", O_CTRL, 32'd0);
        check_value("errw_mtime", mtime, 64'd2);
        bus_write(O_STATUS, 32'd1, 4'hF, er);
        check_value("status_w_err", {63'd0, er}, 64'd0);
        read_check("status_w_val", O_STATUS, 32'd0);

        // Byte strobes.
        wr(O_MLO, 32'h1234_5678);
        bus_write(O_MLO, 32'h0000_00AA, 4'b0001, er);
        read_check("strb_mlo", O_MLO, 32'h1234_56AA);
        bus_write(O_PRE, 32'hBEEF_0102, 4'b0010, er);
        read_check("strb_pre", O_PRE, 32'h0000_0100);

        // IRQ_EN gating with PENDING already set.
        read_check("pend_set", O_STATUS, 32'd1);
        wr(O_CTRL, 32'd2);
        check_value("ie_edge", {63'd0, irq}, 64'd0);
        @(posedge clk_i);
        #1;
        check_value("ie_rise", {63'd0, irq}, 64'd1);
        wr(O_CTRL, 32'd0);
        check_value("ie_clr_edge", {63'd0, irq}, 64'd1);
        @(posedge clk_i);
        #1;
        check_value("ie_clr_fall", {63'd0, irq}, 64'd0);

        // Asynchronous reset mid-operation.
        wr(O_CTRL, 32'd3);
        @(posedge clk_i);
        #1;
        check_value("arst_pre_irq", {63'd0, irq}, 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_value("arst_irq", {63'd0, irq}, 64'd0);
        check_value("arst_mtime", mtime, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        read_check("arst_ctrl", O_CTRL, 32'd0);
        read_check("arst_chi", O_CHI, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
